// File: rtl/key_event_decoder.sv
// Purpose : classifies debounced per-key levels into short / double / long / repeat gesture pulses.
// Latency : every output is registered; a pulse is high for the single cycle after the edge that decides it.
// Backpressure: none; pulses are fire-and-forget and each channel runs independently every cycle.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset; all channels return to IDLE, outputs cleared
//   key_in       debounced key levels (1 = pressed), synchronous to clk
//   short_pulse  one-cycle pulse per key: single short press confirmed (gap window expired)
//   double_pulse one-cycle pulse per key: second release of a double click
//   long_pulse   one-cycle pulse per key: hold reached the long-press threshold
//   repeat_pulse one-cycle pulse per key: auto-repeat tick while long-held
//   long_hold    level per key: high while the channel sits in LONG
//
// Each TIME_* must be at least 2, and CNT_W must be able to hold the largest TIME_* - 1.

module key_event_decoder #(
    parameter int KEY_W       = 3,
    parameter int CNT_W       = 26,
    parameter int TIME_LONG   = 50_000_000,
    parameter int TIME_DOUBLE = 15_000_000,
    parameter int TIME_REPEAT = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] short_pulse,
    output logic [KEY_W-1:0] double_pulse,
    output logic [KEY_W-1:0] long_pulse,
    output logic [KEY_W-1:0] repeat_pulse,
    output logic [KEY_W-1:0] long_hold
);

    // Explicit 3-bit encoding; the three spare codes are caught by the
    // default branch of the next-state logic and sent back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_LONG   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PRESS2 = 3'd4
    } state_e;

    // Terminal counts: the counter is compared against TIME_* - 1 so that the
    // event lands exactly TIME_* edges after the entry edge (entry clears to 0).
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(TIME_LONG - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(TIME_DOUBLE - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(TIME_REPEAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    for (genvar g = 0; g < KEY_W; g++) begin : g_chan

        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        logic short_q,  short_d;
        logic double_q, double_d;
        logic long_q,   long_d;
        logic repeat_q, repeat_d;
        logic hold_q,   hold_d;

        logic key;
        assign key = key_in[g];

        // ------------------------------------------------------------------
        // State, counter and output registers
        // ------------------------------------------------------------------
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                short_q  <= 1'b0;
                double_q <= 1'b0;
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
                hold_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                short_q  <= short_d;
                double_q <= double_d;
                long_q   <= long_d;
                repeat_q <= repeat_d;
                hold_q   <= hold_d;
            end
        end

        // ------------------------------------------------------------------
        // Next-state and counter logic
        // ------------------------------------------------------------------
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (key) begin
                        state_d = ST_PRESS1;
                    end
                end

                // Release is tested first: a release on the threshold edge
                // is still a short press, never a long one.
                ST_PRESS1: begin
                    if (!key) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = ST_LONG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                // Counter restarts after every repeat tick, so ticks stay
                // exactly TIME_REPEAT apart for as long as the key is held.
                ST_LONG: begin
                    if (!key) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == REPEAT_LAST) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                // A re-press on the expiry edge still counts as the second
                // click of a double click.
                ST_GAP: begin
                    if (key) begin
                        state_d = ST_PRESS2;
                        cnt_d   = '0;
                    end else if (cnt_q == DOUBLE_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                // Second press is untimed: it can never turn into a long press.
                ST_PRESS2: begin
                    cnt_d = '0;
                    if (!key) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // ------------------------------------------------------------------
        // Output decode: each pulse mirrors one transition of the next-state
        // logic, and since each lives in a different state at most one of
        // them can be set per cycle.
        // ------------------------------------------------------------------
        always_comb begin
            short_d  = 1'b0;
            double_d = 1'b0;
            long_d   = 1'b0;
            repeat_d = 1'b0;
            case (state_q)
                ST_PRESS1: long_d   = key && (cnt_q == LONG_LAST);
                ST_LONG:   repeat_d = key && (cnt_q == REPEAT_LAST);
                ST_GAP:    short_d  = !key && (cnt_q == DOUBLE_LAST);
                ST_PRESS2: double_d = !key;
                default:   ;
            endcase
            hold_d = (state_d == ST_LONG);
        end

        assign short_pulse[g]  = short_q;
        assign double_pulse[g] = double_q;
        assign long_pulse[g]   = long_q;
        assign repeat_pulse[g] = repeat_q;
        assign long_hold[g]    = hold_q;
    end

endmodule
